// File: rtl/anim_sequencer.sv
// Sprite-animation sequencer: paces frame steps with an enable counter, commits
// them only on frame_sync, and returns registered frame-ROM pixel data.
module anim_sequencer #(
  parameter int FRAMES   = 16,
  parameter int PERIOD   = 33554432,
  parameter int COORD_W  = 8,
  parameter int PIX_W    = 16,
  parameter bit AUTOPLAY = 1'b1,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play,
  input  logic                    restart,
  input  logic [1:0]              mode,
  input  logic                    frame_sync,
  input  logic [COORD_W-1:0]      ram_addr_x,
  input  logic [COORD_W-1:0]      ram_addr_y,
  output logic [FW+2*COORD_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]        rom_data,
  output logic [PIX_W-1:0]        ram_data,
  output logic [FW-1:0]           frame,
  output logic                    done,
  output logic                    frame_changed
);

  typedef enum logic { DIR_UP = 1'b0, DIR_DOWN = 1'b1 } dir_t;

  localparam logic [1:0]    MODE_LOOP    = 2'd0;
  localparam logic [1:0]    MODE_PING    = 2'd1;
  localparam logic [1:0]    MODE_ONESHOT = 2'd2;
  localparam logic [1:0]    MODE_HOLD    = 2'd3;
  localparam logic [FW-1:0] FRAME_ZERO   = {FW{1'b0}};
  localparam logic [FW-1:0] FRAME_ONE    = FW'(1'b1);
  localparam logic [FW-1:0] LAST_FRAME   = FW'(FRAMES - 1);
  localparam logic [FW-1:0] PREV_LAST    = (FRAMES > 1) ? FW'(FRAMES - 2) : {FW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX      = CW'(PERIOD - 1);

  logic [CW-1:0]    cnt_r, cnt_next_s;
  logic             pending_r, pending_next_s;
  logic [FW-1:0]    frame_r, frame_next_s, frame_step_s;
  dir_t             dir_r, dir_next_s, dir_step_s;
  logic             done_r, done_next_s, done_step_s;
  logic             changed_r, changed_next_s;
  logic             playing_r;
  logic [1:0]       mode_r;
  logic [PIX_W-1:0] ram_data_r;
  logic             run_s, expire_s, advance_s, mode_chg_s;

  // play is registered so that AUTOPLAY defines the playing state out of reset
  assign run_s      = playing_r && !done_r && (mode != MODE_HOLD);
  assign expire_s   = run_s && (cnt_r == CNT_MAX);
  assign advance_s  = frame_sync && run_s && (pending_r || expire_s);
  assign mode_chg_s = (mode != mode_r);

  // Candidate next frame/direction/done for the current mode
  always_comb begin
    frame_step_s = frame_r;
    dir_step_s   = dir_r;
    done_step_s  = 1'b0;
    case (mode)
      MODE_LOOP: begin
        if (frame_r == LAST_FRAME) frame_step_s = FRAME_ZERO;
        else                       frame_step_s = frame_r + FRAME_ONE;
      end
      MODE_PING: begin
        if (FRAMES == 1) begin
          frame_step_s = FRAME_ZERO;
          dir_step_s   = DIR_UP;
        end else if (dir_r == DIR_UP) begin
          if (frame_r == LAST_FRAME) begin
            frame_step_s = PREV_LAST;
            dir_step_s   = DIR_DOWN;
          end else begin
            frame_step_s = frame_r + FRAME_ONE;
            dir_step_s   = DIR_UP;
          end
        end else begin
          if (frame_r == FRAME_ZERO) begin
            frame_step_s = FRAME_ONE;
            dir_step_s   = DIR_UP;
          end else begin
            frame_step_s = frame_r - FRAME_ONE;
            dir_step_s   = DIR_DOWN;
          end
        end
      end
      MODE_ONESHOT: begin
        if (frame_r == LAST_FRAME) frame_step_s = LAST_FRAME;
        else                       frame_step_s = frame_r + FRAME_ONE;
        if (frame_step_s == LAST_FRAME) done_step_s = 1'b1;
        else                            done_step_s = 1'b0;
      end
      MODE_HOLD: begin
        frame_step_s = frame_r;
      end
      default: begin
        frame_step_s = frame_r;
      end
    endcase
  end

  // Next-state selection: restart, then advance, then timer and mode-change effects
  always_comb begin
    cnt_next_s     = cnt_r;
    pending_next_s = pending_r;
    frame_next_s   = frame_r;
    dir_next_s     = dir_r;
    done_next_s    = done_r;
    changed_next_s = 1'b0;
    if (restart) begin
      cnt_next_s     = {CW{1'b0}};
      pending_next_s = 1'b0;
      frame_next_s   = FRAME_ZERO;
      dir_next_s     = DIR_UP;
      done_next_s    = 1'b0;
      changed_next_s = (frame_r != FRAME_ZERO);
    end else begin
      if (expire_s)   cnt_next_s = {CW{1'b0}};
      else if (run_s) cnt_next_s = cnt_r + CW'(1'b1);
      else            cnt_next_s = cnt_r;
      if (advance_s) begin
        pending_next_s = 1'b0;
        frame_next_s   = frame_step_s;
        dir_next_s     = dir_step_s;
        done_next_s    = done_step_s;
        changed_next_s = (frame_step_s != frame_r);
      end else begin
        if (expire_s) pending_next_s = 1'b1;
        else          pending_next_s = pending_r;
        if (mode_chg_s) done_next_s = 1'b0;
        else            done_next_s = done_r;
      end
    end
  end

  // Sequencer state and registered pixel output
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      pending_r  <= 1'b0;
      frame_r    <= FRAME_ZERO;
      dir_r      <= DIR_UP;
      done_r     <= 1'b0;
      changed_r  <= 1'b0;
      playing_r  <= AUTOPLAY;
      mode_r     <= MODE_LOOP;
      ram_data_r <= {PIX_W{1'b0}};
    end else begin
      cnt_r      <= cnt_next_s;
      pending_r  <= pending_next_s;
      frame_r    <= frame_next_s;
      dir_r      <= dir_next_s;
      done_r     <= done_next_s;
      changed_r  <= changed_next_s;
      playing_r  <= play;
      mode_r     <= mode;
      ram_data_r <= rom_data;
    end
  end

  assign rom_addr      = {frame_r, ram_addr_y, ram_addr_x};
  assign ram_data      = ram_data_r;
  assign frame         = frame_r;
  assign done          = done_r;
  assign frame_changed = changed_r;

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
Parametrised sprite-animation sequencer for the VGA pixel path. Steps a frame index at a programmable rate and supports loop, ping-pong, one-shot and hold modes. Frame changes are deferred to the display frame boundary so a frame never tears. It forms the frame-ROM address from the pixel coordinate and returns registered pixel data. Runs entirely on the system clock using an internal enable tick; no derived clocks.

Parameters:
FRAMES, 16, number of animation frames (1..256)
PERIOD, 33554432, system-clock cycles per frame step (>=1)
COORD_W, 8, width of each pixel coordinate
PIX_W, 16, pixel data width
AUTOPLAY, 1, value of the playing state after reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
play  input  1  level; 1 = timer runs, 0 = paused (frame held)
restart  input  1  single-cycle pulse; rewind to frame 0
mode  input  2  0 loop, 1 ping-pong, 2 one-shot, 3 hold
frame_sync  input  1  single-cycle pulse at the display frame boundary (vsync)
ram_addr_x  input  COORD_W  current pixel x
ram_addr_y  input  COORD_W  current pixel y
rom_addr  output  FW+2*COORD_W  {frame, y, x} to frame ROM; FW = max(1, clog2(FRAMES))
rom_data  input  PIX_W  combinational ROM read data for rom_addr
ram_data  output  PIX_W  registered pixel
frame  output  FW  displayed frame index
done  output  1  one-shot finished (sticky until restart/rst/mode change)
frame_changed  output  1  one-cycle pulse when frame updates

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. On rst: frame=0, dir=up, tick counter=0, pending=0, done=0, frame_changed=0, ram_data=0, playing=AUTOPLAY.
- Timer: while play=1, done=0 and mode!=3, the counter increments each cycle. At PERIOD-1 it wraps to 0 and sets pending. Paused or hold: the counter and pending both hold. Multiple expiries before frame_sync collapse into one pending step; no step is queued twice.
- Advance: on a frame_sync cycle with pending=1 (or with the counter expiring in that same cycle), the next frame is computed, frame updates on the following edge, pending clears and frame_changed pulses for 1 cycle. Without frame_sync, frame never changes.
- Next-frame rules, using the mode sampled at advance:
  - loop: FRAMES-1 -> 0, else +1.
  - ping-pong: in the up direction, at FRAMES-1 the direction flips to down and the frame becomes FRAMES-2; in the down direction, at 0 the direction flips to up and the frame becomes 1; otherwise step by ±1.
  - one-shot: +1. Reaching FRAMES-1 sets done. With done=1 the timer stops and there are no further advances.
  - hold: no advance.
- FRAMES=1: frame is constant 0. Ping-pong stays at 0. One-shot sets done on its first advance.
- restart: highest priority after rst. Sets frame=0, dir=up, counter=0, pending=0, done=0. frame_changed pulses only if frame was nonzero. A coincident advance is discarded.
- Mode change: clears done and leaves frame unchanged. If frame is above the new range rules (ping-pong with dir down at 0), the normal rules apply on the next advance.
- Pixel path: rom_addr is combinational from the current frame and inputs. ram_data <= rom_data every cycle, giving 1-cycle latency from coordinate to data. A frame update takes effect in rom_addr the cycle after the advancing edge.
- Widths: the counter is clog2(PERIOD) bits, minimum 1. All arithmetic is unsigned with no overflow past FRAMES-1.

Test Plan:
All scenarios use FRAMES=4, PERIOD=4, frame_sync every 10 cycles.
1. Reset then play=1, mode=0 -> frame sequence 0,1,2,3,0,1 at successive frame_sync, with a frame_changed pulse each time. Apply rst mid-sequence -> frame=0 and ram_data=0 on the next edge.
2. mode=1 -> frame sequence 0,1,2,3,2,1,0,1; direction flips exactly at 3 and at 0.
3. mode=2 -> frame sequence 0,1,2,3 with done=1 at 3; frame holds for 50 cycles. Pulse restart -> frame=0, done=0, sequence resumes.
4. play=0 for 30 cycles mid-count -> frame and counter frozen; resume -> counter continues from its held value. Hold PERIOD=4 with frame_sync every 20 cycles -> exactly one step per frame_sync (no skipped frames).
5. Drive x=5, y=3, frame=2 with the ROM model data = {frame,y,x} -> ram_data=0x0203_05 pattern (truncated to PIX_W) one cycle later. restart and frame_sync in the same cycle -> frame=0 and no advance.
6. FRAMES=1 build, all modes -> frame stays 0. One-shot -> done=1 after the first frame_sync following expiry.
